// File: rtl/bolt_slot_arbiter.sv
// Bolt slot arbiter: turns player fire-key edges and per-column invader fire requests into
// one-cycle slot launch grants, with per-side frame cooldowns and round-robin column sharing.
module bolt_slot_arbiter #(
    parameter int PLR_SLOTS    = 4,
    parameter int INV_SLOTS    = 4,
    parameter int PLR_COOLDOWN = 15,
    parameter int INV_COOLDOWN = 40
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_frm_tick,
    input  logic                   i_game_en,
    input  logic                   i_plr_alive,
    input  logic                   i_plr_fire,
    input  logic [7:0]             i_inv_fire_req,
    input  logic [PLR_SLOTS-1:0]   i_btp_done,
    input  logic [INV_SLOTS-1:0]   i_bti_done,
    output logic [PLR_SLOTS-1:0]   o_btp_exs,
    output logic [INV_SLOTS-1:0]   o_bti_exs,
    output logic [PLR_SLOTS-1:0]   o_btp_launch,
    output logic [INV_SLOTS-1:0]   o_bti_launch,
    output logic [3*INV_SLOTS-1:0] o_bti_col
);

    localparam logic [7:0] PLR_CD_INIT = 8'(PLR_COOLDOWN);
    localparam logic [7:0] INV_CD_INIT = 8'(INV_COOLDOWN);

    logic                   r_prev_fire;
    logic [7:0]             r_plr_cd;
    logic [7:0]             r_inv_cd;
    logic [2:0]             r_rr_ptr;
    logic [PLR_SLOTS-1:0]   r_btp_exs;
    logic [PLR_SLOTS-1:0]   r_btp_launch;
    logic [INV_SLOTS-1:0]   r_bti_exs;
    logic [INV_SLOTS-1:0]   r_bti_launch;
    logic [3*INV_SLOTS-1:0] r_bti_col;

    logic                   w_plr_edge;
    logic                   w_plr_accept;
    logic                   w_inv_accept;
    logic [3:0]             w_col_pick;
    logic [PLR_SLOTS-1:0]   w_plr_grant;
    logic [INV_SLOTS-1:0]   w_inv_grant;

    function automatic logic [PLR_SLOTS-1:0] pick_plr(input logic [PLR_SLOTS-1:0] exs);
        logic [PLR_SLOTS-1:0] oh;
        oh = {PLR_SLOTS{1'b0}};
        for (int k = PLR_SLOTS - 1; k >= 0; k--) begin
            if (!exs[k]) oh = {PLR_SLOTS{1'b0}} | (PLR_SLOTS'(1) << k);
        end
        return oh;
    endfunction

    function automatic logic [INV_SLOTS-1:0] pick_inv(input logic [INV_SLOTS-1:0] exs);
        logic [INV_SLOTS-1:0] oh;
        oh = {INV_SLOTS{1'b0}};
        for (int k = INV_SLOTS - 1; k >= 0; k--) begin
            if (!exs[k]) oh = {INV_SLOTS{1'b0}} | (INV_SLOTS'(1) << k);
        end
        return oh;
    endfunction

    // Returns {found, column}: first requesting column at or after ptr, wrapping mod 8.
    function automatic logic [3:0] pick_col(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] c;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            c = ptr + 3'(k);
            if (req[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign w_plr_edge   = i_plr_fire & ~r_prev_fire;
    assign w_plr_accept = w_plr_edge & i_game_en & i_plr_alive & (r_plr_cd == 8'd0) & ~(&r_btp_exs);
    assign w_plr_grant  = w_plr_accept ? pick_plr(r_btp_exs) : {PLR_SLOTS{1'b0}};
    assign w_col_pick   = pick_col(i_inv_fire_req, r_rr_ptr);
    assign w_inv_accept = i_frm_tick & i_game_en & (r_inv_cd == 8'd0) & ~(&r_bti_exs) & w_col_pick[3];
    assign w_inv_grant  = w_inv_accept ? pick_inv(r_bti_exs) : {INV_SLOTS{1'b0}};

    // Player side: key history, slot occupancy, launch pulse and cooldown.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_fire  <= 1'b1;
            r_plr_cd     <= 8'd0;
            r_btp_exs    <= {PLR_SLOTS{1'b0}};
            r_btp_launch <= {PLR_SLOTS{1'b0}};
        end else begin
            r_prev_fire  <= i_plr_fire;
            r_btp_launch <= w_plr_grant;
            if (!i_game_en) begin
                r_plr_cd  <= 8'd0;
                r_btp_exs <= {PLR_SLOTS{1'b0}};
            end else begin
                r_btp_exs <= (r_btp_exs & ~i_btp_done) | w_plr_grant;
                if (w_plr_accept) begin
                    r_plr_cd <= PLR_CD_INIT;
                end else if (i_frm_tick && (r_plr_cd != 8'd0)) begin
                    r_plr_cd <= r_plr_cd - 8'd1;
                end
            end
        end
    end

    // Invader side: once per frame, one column wins round-robin and takes the lowest free slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inv_cd     <= 8'd0;
            r_rr_ptr     <= 3'd0;
            r_bti_exs    <= {INV_SLOTS{1'b0}};
            r_bti_launch <= {INV_SLOTS{1'b0}};
            r_bti_col    <= {(3*INV_SLOTS){1'b0}};
        end else begin
            r_bti_launch <= w_inv_grant;
            if (!i_game_en) begin
                r_inv_cd  <= 8'd0;
                r_rr_ptr  <= 3'd0;
                r_bti_exs <= {INV_SLOTS{1'b0}};
            end else begin
                r_bti_exs <= (r_bti_exs & ~i_bti_done) | w_inv_grant;
                if (w_inv_accept) begin
                    r_inv_cd <= INV_CD_INIT;
                    r_rr_ptr <= w_col_pick[2:0] + 3'd1;
                end else if (i_frm_tick && (r_inv_cd != 8'd0)) begin
                    r_inv_cd <= r_inv_cd - 8'd1;
                end
                for (int k = 0; k < INV_SLOTS; k++) begin
                    if (w_inv_grant[k]) r_bti_col[3*k +: 3] <= w_col_pick[2:0];
                end
            end
        end
    end

    assign o_btp_exs    = r_btp_exs;
    assign o_bti_exs    = r_bti_exs;
    assign o_btp_launch = r_btp_launch;
    assign o_bti_launch = r_bti_launch;
    assign o_bti_col    = r_bti_col;

endmodule
